adc_bitslip_aligner: RTL
========================

// Module: adc_bitslip_aligner
// PURPOSE
//  Link-training controller for one 2-lane ADC channel. It is the upstream driver of the
//  channel's adc_io_reset/adc_bitslip inputs and consumes the channel's 12-bit adc_bits
//  output. ADC is set to a known training pattern. Block resets ISERDES, then bitslips each
//  6-bit lane until it matches its pattern half. Reports per-lane lock/fail.
// PARAMETERS
//  IORST_CYCLES  4   lclk cycles adc_io_reset is held high
//  SETTLE        8   wait cycles after io_reset or bitslip before comparing (covers SERDES+2 regs)
//  MATCH_COUNT   16  consecutive matching words required to declare lane locked
//  MAX_SLIPS     6   bitslips tried per lane before fail (= lane word width)
// PORTS
//  lclk          in   1   word clock (same lclk as ADC data path)
//  reset_n       in   1   asynchronous active-low reset
//  start         in   1   1-cycle pulse: begin training; ignored while busy
//  pattern       in   12  expected word; [5:0] lane 0, [11:6] lane 1
//  adc_bits      in   12  deserialized word from the channel; [5:0] lane 0, [11:6] lane 1
//  adc_io_reset  out  2   ISERDES reset per lane
//  adc_bitslip   out  2   1-cycle bitslip pulse per lane
//  busy          out  1   training in progress
//  done          out  1   1-cycle pulse when training ends
//  locked        out  2   lane aligned (sticky until next start)
//  fail          out  2   lane exhausted MAX_SLIPS without lock (sticky until next start)
//  slip_cnt_0    out  3   bitslips issued on lane 0 this run
//  slip_cnt_1    out  3   bitslips issued on lane 1 this run
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. All logic on lclk.
//  - Outputs are registered. adc_bitslip is never high 2 cycles in a row.
//  - IDLE: start=1 -> clear locked/fail/slip_cnt/match ctrs, busy=1, go IORST.
//  - IORST: adc_io_reset=2'b11 for IORST_CYCLES cycles -> WAIT.
//  - WAIT: count SETTLE cycles, adc_bits ignored -> CHECK.
//  - CHECK (per active lane = !locked && !fail):
//    - word==pattern half: match_ctr++. Reaching MATCH_COUNT sets locked.
//    - mismatch: match_ctr<=0, mark lane for slip.
//    Any lane marked -> SLIP next cycle. All lanes locked|fail -> DONE.
//  - SLIP: for each marked lane:
//    - slip_cnt==MAX_SLIPS: set fail, no pulse.
//    - else: adc_bitslip[i]=1 for 1 cycle, slip_cnt++.
//    Other lanes are paused, keep their match_ctr and are not pulsed. Then -> WAIT.
//    If no pulse was issued, go directly to CHECK.
//  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
//  - Lock in the same CHECK cycle as the other lane's mismatch: lock wins, only mismatched lane slips.
//  - start while busy is ignored. reset_n low mid-run aborts immediately: outputs to reset values.
//  - A locked lane is not re-checked after lock. Mismatches after lock do not clear locked.
//  - Widths: match_ctr $clog2(MATCH_COUNT+1) bits. Saturates at MATCH_COUNT.
// STRUCTURE
//  - Shared package adc_align_pkg holds:
//    - FSM state enum {IDLE, IORST, WAIT, CHECK, SLIP, DONE}
//    - lane width constant LANE_BITS=6
//    - NUM_LANES=2
//  - Sub-module adc_lane_align_tracker, instanced per lane:
//    - inputs: compare, clear, slip_grant
//    - holds match_ctr, slip_cnt, locked, fail
//    - outputs: mismatch, slip pulse request
//  - Top holds the shared FSM and the SETTLE/IORST timers.
// TESTING
//  1. Lanes already aligned, pattern=12'hA5C:
//     start -> io_reset 4 cycles, no bitslip, locked=2'b11, fail=0, done pulse,
//     slip_cnt=0/0.
//  2. Lane 0 rotated by 2, lane 1 aligned:
//     exactly 2 bitslip pulses on lane 0, each followed by >=8 quiet cycles;
//     slip_cnt_0=2, slip_cnt_1=0, locked=2'b11.
//  3. Lane 1 never matches (held 6'h00 vs pattern 6'h2A):
//     6 pulses on lane 1, then fail[1]=1, locked[1]=0; lane 0 still locks; done pulses once.
//  4. Glitch: lane 0 matches 10 words, 1 bad word, then matches:
//     match counter restarts, one slip issued, lock needs a fresh 16 matches.
//  5. reset_n low during SLIP:
//     outputs 0 at once; a later start runs a full fresh sequence with counters from 0.
//  6. start pulsed while busy: no restart and no counter clear; second start after done retrains.

Source files
------------

// File: rtl/adc_align_pkg.sv
// rtl/adc_align_pkg.sv - shared types and constants for the ADC lane bitslip aligner
package adc_align_pkg;

  localparam int LANE_BITS = 6;
  localparam int NUM_LANES = 2;

  typedef enum logic [2:0] {
    IDLE,
    IORST,
    WAIT,
    CHECK,
    SLIP,
    DONE
  } state_e;

endpackage

// File: rtl/adc_bitslip_aligner_if.sv
// rtl/adc_bitslip_aligner_if.sv - aligner <-> ADC channel deserializer link
interface adc_bitslip_aligner_if;
  import adc_align_pkg::*;

  logic [NUM_LANES*LANE_BITS-1:0] adc_bits;
  logic [NUM_LANES-1:0]           adc_io_reset;
  logic [NUM_LANES-1:0]           adc_bitslip;

  modport master (input adc_bits, output adc_io_reset, output adc_bitslip);
  modport slave  (output adc_bits, input adc_io_reset, input adc_bitslip);

endinterface

// File: rtl/adc_lane_align_tracker.sv
// rtl/adc_lane_align_tracker.sv - per-lane match counting, slip budget and lock/fail flags
module adc_lane_align_tracker
  import adc_align_pkg::*;
#(
  parameter int  LANE_W      = LANE_BITS,
  parameter int  MATCH_COUNT = 16,
  parameter int  MAX_SLIPS   = 6,
  localparam int MW          = $clog2(MATCH_COUNT + 1),
  localparam int SW          = $clog2(MAX_SLIPS + 1)
) (
  input  logic              lclk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              compare,
  input  logic              slip_grant,
  input  logic [LANE_W-1:0] word,
  input  logic [LANE_W-1:0] pat,
  output logic              mismatch,
  output logic              slip_req,
  output logic              settled,
  output logic              locked,
  output logic              fail,
  output logic [SW-1:0]     slip_cnt
);

  logic [MW-1:0] match_ctr_q, match_ctr_d;
  logic [SW-1:0] slip_cnt_q, slip_cnt_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          marked_q, marked_d;
  logic          active, match, lock_now;

  assign active   = !locked_q && !fail_q;
  assign match    = (word == pat);
  assign mismatch = compare && active && !match;
  assign lock_now = compare && active && match && (match_ctr_q == MW'(MATCH_COUNT - 1));
  // A lane that locks this cycle already counts as finished for the DONE decision.
  assign settled  = locked_q || fail_q || lock_now;
  assign slip_req = slip_grant && marked_q && (slip_cnt_q != SW'(MAX_SLIPS));

  always_comb begin
    match_ctr_d = match_ctr_q;
    slip_cnt_d  = slip_cnt_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    marked_d    = marked_q;
    if (clear) begin
      match_ctr_d = '0;
      slip_cnt_d  = '0;
      locked_d    = 1'b0;
      fail_d      = 1'b0;
      marked_d    = 1'b0;
    end else begin
      if (compare && active) begin
        if (match) begin
          if (match_ctr_q < MW'(MATCH_COUNT)) match_ctr_d = match_ctr_q + 1'b1;
          if (lock_now) locked_d = 1'b1;
        end else begin
          match_ctr_d = '0;
          marked_d    = 1'b1;
        end
      end
      if (slip_grant && marked_q) begin
        marked_d = 1'b0;
        if (slip_cnt_q == SW'(MAX_SLIPS)) fail_d = 1'b1;
        else slip_cnt_d = slip_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      match_ctr_q <= '0;
      slip_cnt_q  <= '0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      marked_q    <= 1'b0;
    end else begin
      match_ctr_q <= match_ctr_d;
      slip_cnt_q  <= slip_cnt_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      marked_q    <= marked_d;
    end
  end

  assign locked   = locked_q;
  assign fail     = fail_q;
  assign slip_cnt = slip_cnt_q;

endmodule

// File: rtl/adc_bitslip_aligner.sv
// rtl/adc_bitslip_aligner.sv - link-training FSM: ISERDES reset, settle, compare and bitslip per lane
module adc_bitslip_aligner
  import adc_align_pkg::*;
#(
  parameter int IORST_CYCLES = 4,
  parameter int SETTLE       = 8,
  parameter int MATCH_COUNT  = 16,
  parameter int MAX_SLIPS    = 6
) (
  input  logic                         lclk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NUM_LANES*LANE_BITS-1:0] pattern,
  adc_bitslip_aligner_if.master        adc,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_LANES-1:0]         locked,
  output logic [NUM_LANES-1:0]         fail,
  output logic [2:0]                   slip_cnt_0,
  output logic [2:0]                   slip_cnt_1
);

  localparam int TMAX = (IORST_CYCLES > SETTLE) ? IORST_CYCLES : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(MAX_SLIPS + 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [NUM_LANES-1:0] io_reset_q, bitslip_q;
  logic                 busy_q, done_q;

  logic                 clear, compare, slip_grant;
  logic [NUM_LANES-1:0] mismatch, slip_req, settled, lane_locked, lane_fail;
  logic [SW-1:0]        lane_slips [NUM_LANES];

  assign clear      = (state_q == IDLE) && start;
  assign compare    = (state_q == CHECK);
  assign slip_grant = (state_q == SLIP);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    adc_lane_align_tracker #(
      .LANE_W      (LANE_BITS),
      .MATCH_COUNT (MATCH_COUNT),
      .MAX_SLIPS   (MAX_SLIPS)
    ) u_tracker (
      .lclk       (lclk),
      .reset_n    (reset_n),
      .clear      (clear),
      .compare    (compare),
      .slip_grant (slip_grant),
      .word       (adc.adc_bits[i*LANE_BITS +: LANE_BITS]),
      .pat        (pattern[i*LANE_BITS +: LANE_BITS]),
      .mismatch   (mismatch[i]),
      .slip_req   (slip_req[i]),
      .settled    (settled[i]),
      .locked     (lane_locked[i]),
      .fail       (lane_fail[i]),
      .slip_cnt   (lane_slips[i])
    );
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    unique case (state_q)
      IDLE:    if (start) state_d = IORST;
      IORST:   if (tmr_q == TW'(IORST_CYCLES - 1)) state_d = WAIT;
      WAIT:    if (tmr_q == TW'(SETTLE - 1)) state_d = CHECK;
      CHECK: begin
        if (|mismatch) state_d = SLIP;
        else if (&settled) state_d = DONE;
      end
      // A lane that only ran out of slips needs no settle time before the next compare.
      SLIP:    state_d = (|slip_req) ? WAIT : CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      io_reset_q <= '0;
      bitslip_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      io_reset_q <= {NUM_LANES{state_d == IORST}};
      bitslip_q  <= slip_req;
      busy_q     <= (state_d != IDLE) && (state_d != DONE);
      done_q     <= (state_d == DONE);
    end
  end

  assign adc.adc_io_reset = io_reset_q;
  assign adc.adc_bitslip  = bitslip_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign locked           = lane_locked;
  assign fail             = lane_fail;
  assign slip_cnt_0       = 3'(lane_slips[0]);
  assign slip_cnt_1       = 3'(lane_slips[1]);

endmodule
